// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the multi-cycle ALU.
// Opcode values match the original single-cycle datapath ALU's Sel field.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter(input logic [3:0] sel);
        return (sel == OP_MUL) || (sel == OP_DIVU) || (sel == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one accumulator.
// done/result/ovf describe the value being written on the final step edge.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic               busy_q;
    logic               div_q;
    logic               rem_q;
    logic [CNT_W-1:0]   cnt_q;
    // MUL: acc = partial product, shreg = shifted multiplicand.
    // DIV: acc = {remainder, dividend/quotient}, shreg[WIDTH-1:0] = divisor.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    always_comb begin
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        mplier_d = mplier_q;
        rem_sh   = '0;
        diff     = '0;
        if (div_q) begin
            rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            diff   = rem_sh - {1'b0, shreg_q[WIDTH-1:0]};
            if (!diff[WIDTH]) begin
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (mplier_q[0]) begin
                acc_d = acc_q + shreg_q;
            end
            shreg_d  = shreg_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    assign done   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign result = (div_q && rem_q) ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
    assign ovf    = div_q ? (shreg_q[WIDTH-1:0] == '0) : (acc_d[2*WIDTH-1:WIDTH] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            shreg_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            div_q    <= op_div;
            rem_q    <= op_rem;
            cnt_q    <= '0;
            acc_q    <= op_div ? {{WIDTH{1'b0}}, a} : '0;
            shreg_q  <= op_div ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops plus iterative MUL/DIVU/REMU,
// with valid/ready handshake on both sides and registered result/flags.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             ZF,
    output logic             OVF
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] resultado_q;
    logic             zf_q;
    logic             ovf_q;

    logic [WIDTH-1:0] fast_res_d;
    logic             fast_ovf_d;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] dif_d;
    logic [SH_W-1:0]  shamt;
    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_res;
    logic             iter_ovf;

    assign shamt = OP2[SH_W-1:0];
    assign sum_d = OP1 + OP2;
    assign dif_d = OP1 - OP2;

    always_comb begin
        fast_res_d = '0;
        fast_ovf_d = 1'b0;
        case (Sel)
            OP_AND: fast_res_d = OP1 & OP2;
            OP_OR:  fast_res_d = OP1 | OP2;
            OP_NOR: fast_res_d = ~(OP1 | OP2);
            OP_ADD: begin
                fast_res_d = sum_d;
                fast_ovf_d = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum_d[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_SUB: begin
                fast_res_d = dif_d;
                fast_ovf_d = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (dif_d[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_SLT: fast_res_d = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
            OP_SLL: fast_res_d = OP1 << shamt;
            OP_SRL: fast_res_d = OP1 >> shamt;
            OP_SRA: fast_res_d = $unsigned($signed(OP1) >>> shamt);
            default: begin
                fast_res_d = '0;
                fast_ovf_d = 1'b0;
            end
        endcase
    end

    assign accept     = (state_q == ST_IDLE) && in_ready_q && in_valid;
    assign iter_start = accept && is_iter(Sel);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .op_div (Sel != OP_MUL),
        .op_rem (Sel == OP_REMU),
        .a      (OP1),
        .b      (OP2),
        .done   (iter_done),
        .result (iter_res),
        .ovf    (iter_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            resultado_q <= '0;
            zf_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (is_iter(Sel)) begin
                            state_q <= ST_ITER;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            resultado_q <= fast_res_d;
                            zf_q        <= (fast_res_d == '0);
                            ovf_q       <= fast_ovf_d;
                        end
                    end
                end
                ST_ITER: begin
                    if (iter_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        resultado_q <= iter_res;
                        zf_q        <= (iter_res == '0);
                        ovf_q       <= iter_ovf;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE costs one bubble: no accept on the take edge.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign resultado = resultado_q;
    assign ZF        = zf_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases, randomized ops against an
// arithmetic reference model, backpressure and mid-operation reset.
module tb_alu_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [3:0]  Sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] resultado;
    logic        ZF;
    logic        OVF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multiciclo #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .OP1       (OP1),
        .OP2       (OP2),
        .Sel       (Sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .ZF        (ZF),
        .OVF       (OVF)
    );

    function automatic logic is_long(input logic [3:0] sel);
        return (sel == 4'b1000) || (sel == 4'b1001) || (sel == 4'b1010);
    endfunction

    // Arithmetic reference: 64-bit math, signed range checks, plain operators.
    function automatic void ref_model(input logic [3:0] sel, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] r,
                                      output logic ovf);
        longint      sa, sb, s;
        logic [63:0] p;
        int          amt;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b[4:0]);
        r   = 32'd0;
        ovf = 1'b0;
        case (sel)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin s = sa + sb; r = a + b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; r = a - b; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            4'b0011: r = a << amt;
            4'b0100: r = a >> amt;
            4'b0101: r = $unsigned($signed(a) >>> amt);
            4'b1000: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; ovf = (p[63:32] != 0); end
            4'b1001: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; ovf = (b == 0); end
            4'b1010: begin r = (b == 0) ? a : a % b; ovf = (b == 0); end
            default: begin r = 32'd0; ovf = 1'b0; end
        endcase
    endfunction

    // Issue one op, scramble inputs after accept, wait for result, then take it.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic zf, output logic ovf, output int lat);
        int n;
        n = 0;
        Sel = sel; OP1 = a; OP2 = b; in_valid = 1'b1; out_ready = 1'b0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0; OP1 = $urandom; OP2 = $urandom; Sel = 4'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL timeout sel=%b out_valid=%b required 1", sel, out_valid);
        end
        lat = n + 1;
        r = resultado; zf = ZF; ovf = OVF;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; OP1 = '0; OP2 = '0; Sel = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (resultado !== 32'd0)  begin errors++; $display("FAIL reset_resultado got %h want 0", resultado); end
        checks++; if (ZF !== 1'b0)          begin errors++; $display("FAIL reset_zf got %b want 0", ZF); end
        checks++; if (OVF !== 1'b0)         begin errors++; $display("FAIL reset_ovf got %b want 0", OVF); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0]  sels [10] = '{4'b0010, 4'b0110, 4'b1000, 4'b1000, 4'b1001,
                                   4'b1010, 4'b1001, 4'b1010, 4'b0101, 4'b1111};
        logic [31:0] as   [10] = '{32'h7FFF_FFFF, 32'd5, 32'h0001_0000, 32'd1234, 32'd100,
                                   32'd100, 32'd9, 32'd9, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs   [10] = '{32'd1, 32'd5, 32'h0001_0000, 32'd5678, 32'd7,
                                   32'd7, 32'd0, 32'd0, 32'd4, 32'h0000_00FF};
        logic [31:0] rexp [10] = '{32'h8000_0000, 32'd0, 32'd0, 32'd7006652, 32'd14,
                                   32'd2, 32'hFFFF_FFFF, 32'd9, 32'hF800_0000, 32'd0};
        logic        oexp [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] r;
        logic        zf, ovf;
        int          lat, lexp;
        for (int i = 0; i < 10; i++) begin
            do_op(sels[i], as[i], bs[i], r, zf, ovf, lat);
            lexp = is_long(sels[i]) ? 33 : 1;
            checks++; if (r !== rexp[i]) begin errors++; $display("FAIL dir_res[%0d] got %h want %h", i, r, rexp[i]); end
            checks++; if (zf !== (rexp[i] == 0)) begin errors++; $display("FAIL dir_zf[%0d] got %b want %b", i, zf, rexp[i] == 0); end
            checks++; if (ovf !== oexp[i]) begin errors++; $display("FAIL dir_ovf[%0d] got %b want %b", i, ovf, oexp[i]); end
            checks++; if (lat != lexp) begin errors++; $display("FAIL dir_lat[%0d] got %0d want %0d", i, lat, lexp); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  pool [16] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                                   4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010,
                                   4'b1011, 4'b1101, 4'b1110, 4'b1111};
        logic [3:0]  sel;
        logic [31:0] a, b, r, rexp;
        logic        zf, ovf, oexp;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            sel = pool[$urandom_range(0, 15)];
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            ref_model(sel, a, b, rexp, oexp);
            do_op(sel, a, b, r, zf, ovf, lat);
            checks++;
            if (r !== rexp || zf !== (rexp == 0) || ovf !== oexp || lat != (is_long(sel) ? 33 : 1)) begin
                errors++;
                $display("FAIL rnd sel=%b a=%h b=%h got r=%h zf=%b ovf=%b lat=%0d want r=%h zf=%b ovf=%b",
                         sel, a, b, r, zf, ovf, lat, rexp, rexp == 0, oexp);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        Sel = 4'b1000; OP1 = 32'd3; OP2 = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            OP1 = ~OP1; OP2 = $urandom;
            @(posedge clk); #1; n++;
        end
        checks++; if (resultado !== 32'd21 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_result got %h/%b want 00000015/1", resultado, out_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resultado !== 32'd21 || out_valid !== 1'b1 || in_ready !== 1'b0 || ZF !== 1'b0 || OVF !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got r=%h ov=%b ir=%b want 00000015/1/0", i, resultado, out_valid, in_ready);
            end
        end
        // New op offered on the take edge must wait for the bubble cycle.
        Sel = 4'b0010; OP1 = 32'd1; OP2 = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_take got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || resultado !== 32'd2) begin errors++; $display("FAIL bp_next got ov=%b r=%h want 1/00000002", out_valid, resultado); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] r;
        logic        zf, ovf, seen;
        int          lat;
        Sel = 4'b1001; OP1 = 32'd1000; OP2 = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || resultado !== 32'd0 || ZF !== 1'b0 || OVF !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got ir=%b ov=%b r=%h want 1/0/0", in_ready, out_valid, resultado);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale got out_valid %b want 0", seen); end
        do_op(4'b0010, 32'd2, 32'd3, r, zf, ovf, lat);
        checks++; if (r !== 32'd5 || zf !== 1'b0 || ovf !== 1'b0 || lat != 1) begin errors++; $display("FAIL midrst_add got r=%h lat=%0d want 00000005/1", r, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
